// File: rtl/spi_rd_pkg.sv
// Shared types and frame layout for the SPI count-frame reader.
// Frame: 64 bits MSB first, fs_cnt in the upper word, fx_cnt in the lower word.
package spi_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } rd_state_t;

    localparam int FRAME_BITS = 64;
    localparam int CNT_W      = 32;

    localparam int FS_MSB = 63;
    localparam int FS_LSB = 32;
    localparam int FX_MSB = 31;
    localparam int FX_LSB = 0;

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK divider: SCK toggles every CLK_DIV cycles while en is high, idles low otherwise.
// Strobes mark the cycle at whose end SCK rises (rise_stb) or falls (fall_stb == sample_stb).
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_stb,
    output logic sample_stb,
    output logic fall_stb
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_reg;
    logic       sck_reg;
    logic       phase_end;

    assign phase_end = en && (div_cnt_reg == DIV_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= 8'd0;
            sck_reg     <= 1'b0;
        end else if (!en) begin
            div_cnt_reg <= 8'd0;
            sck_reg     <= 1'b0;
        end else if (phase_end) begin
            div_cnt_reg <= 8'd0;
            sck_reg     <= ~sck_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
        end
    end

    // The last high cycle is both the sampling point and the cycle before the fall.
    assign sck        = sck_reg;
    assign rise_stb   = phase_end && !sck_reg;
    assign sample_stb = phase_end && sck_reg;
    assign fall_stb   = phase_end && sck_reg;

endmodule

// File: rtl/spi_cnt_reader.sv
// SPI mode-0 master reading the 64-bit fs_cnt/fx_cnt frame from the cymometer responder.
// Optional auto-poll timer enabled by defining SPI_RD_AUTO_POLL_EN.
module spi_cnt_reader
    import spi_rd_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int POLL_GAP = 1000
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fs_cnt,
    output logic [CNT_W-1:0] fx_cnt,
    output logic             nCS,
    output logic             SCK,
    input  logic             MISO
);

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [5:0] BIT_LAST   = 6'(FRAME_BITS - 1);

    if (CLK_DIV < 3 || CLK_DIV > 255 || CS_SETUP < 1 || CS_SETUP > 256 ||
        CS_HOLD < 1 || CS_HOLD > 256 || POLL_GAP < 0) begin : g_param_check
        $error("spi_cnt_reader: illegal parameter value");
    end

    rd_state_t             state_reg, state_next;
    logic [7:0]            tmr_reg;
    logic [5:0]            bit_cnt_reg;
    logic                  first_rise_reg;
    logic [FRAME_BITS-1:0] sr_reg;
    logic [CNT_W-1:0]      fs_cnt_reg, fx_cnt_reg;
    logic                  ncs_reg, ncs_next;
    logic                  miso_meta_reg, miso_sync_reg;
    logic                  start_req, start_acc;
    logic                  rise_stb, sample_stb, fall_stb;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .en         (state_reg == ST_SHIFT),
        .sck        (SCK),
        .rise_stb   (rise_stb),
        .sample_stb (sample_stb),
        .fall_stb   (fall_stb)
    );

`ifdef SPI_RD_AUTO_POLL_EN
    localparam int POLL_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

    logic [POLL_W-1:0] poll_cnt_reg;
    logic              poll_arm_reg;
    logic              poll_start;

    // Armed out of reset with a zero count, so the first frame starts right after release.
    assign poll_start = poll_arm_reg && (poll_cnt_reg == '0) && (state_reg == ST_IDLE);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_reg <= '0;
            poll_arm_reg <= 1'b1;
        end else if (state_reg == ST_DONE) begin
            poll_cnt_reg <= POLL_W'(POLL_GAP);
            poll_arm_reg <= 1'b1;
        end else if (start_acc) begin
            poll_arm_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && poll_arm_reg && poll_cnt_reg != '0) begin
            poll_cnt_reg <= poll_cnt_reg - 1'b1;
        end
    end

    assign start_req = start | poll_start;
`else
    assign start_req = start;
`endif

    assign start_acc = (state_reg == ST_IDLE) && start_req;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start_req) state_next = ST_SETUP;
            ST_SETUP: if (tmr_reg == SETUP_LAST) state_next = ST_SHIFT;
            ST_SHIFT: if (fall_stb && bit_cnt_reg == BIT_LAST) state_next = ST_HOLD;
            ST_HOLD:  if (tmr_reg == HOLD_LAST) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // nCS is registered: it drops the cycle after start is accepted and rises after DONE.
    always_comb begin
        busy     = 1'b1;
        done     = 1'b0;
        ncs_next = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                busy     = start_acc;
                ncs_next = !start_acc;
            end
            ST_DONE: begin
                done     = 1'b1;
                ncs_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_reg <= 1'b0;
            miso_sync_reg <= 1'b0;
        end else begin
            miso_meta_reg <= MISO;
            miso_sync_reg <= miso_meta_reg;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_reg        <= 8'd0;
            bit_cnt_reg    <= 6'd0;
            first_rise_reg <= 1'b1;
            sr_reg         <= '0;
            fs_cnt_reg     <= '0;
            fx_cnt_reg     <= '0;
            ncs_reg        <= 1'b1;
        end else begin
            ncs_reg <= ncs_next;

            if (state_reg != state_next) begin
                tmr_reg <= 8'd0;
            end else if (state_reg == ST_SETUP || state_reg == ST_HOLD) begin
                tmr_reg <= tmr_reg + 8'd1;
            end

            // bit_cnt_reg is the index of the bit currently on the wire; the first rise is bit 0.
            if (start_acc) begin
                bit_cnt_reg    <= 6'd0;
                first_rise_reg <= 1'b1;
            end else if (rise_stb) begin
                if (first_rise_reg) begin
                    first_rise_reg <= 1'b0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 6'd1;
                end
            end

            if (start_acc) begin
                sr_reg <= '0;
            end else if (sample_stb) begin
                sr_reg <= {sr_reg[FRAME_BITS-2:0], miso_sync_reg};
            end

            // Publish on entry to DONE so the counts are valid in the done cycle itself.
            if (state_next == ST_DONE && state_reg == ST_HOLD) begin
                fs_cnt_reg <= sr_reg[FS_MSB:FS_LSB];
                fx_cnt_reg <= sr_reg[FX_MSB:FX_LSB];
            end
        end
    end

    assign nCS    = ncs_reg;
    assign fs_cnt = fs_cnt_reg;
    assign fx_cnt = fx_cnt_reg;

endmodule

// File: tb/tb_spi_cnt_reader.sv
// Self-checking bench for spi_cnt_reader: a default instance plus a CLK_DIV=3 instance,
// each driven by a behavioural mode-0 responder that shifts out a programmed 64-bit frame.
module tb_spi_cnt_reader;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic        start3 = 1'b0;

    logic        busy, done, ncs, sck, miso;
    logic [31:0] fs, fx;
    logic        busy3, done3, ncs3, sck3, miso3;
    logic [31:0] fs3, fx3;

    logic [63:0] frame   = '0;
    logic [63:0] frame3  = '0;
    logic [63:0] tx_sr   = '0;
    logic [63:0] tx_sr3  = '0;
    logic        ncs_q   = 1'b1;
    logic        sck_q   = 1'b0;
    logic        ncs3_q  = 1'b1;
    logic        sck3_q  = 1'b0;

    int rises  = 0;
    int rises3 = 0;
    int dones  = 0;
    int total  = 0;
    int bad    = 0;

    always #5 clk = ~clk;

    spi_cnt_reader dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .fs_cnt  (fs),
        .fx_cnt  (fx),
        .nCS     (ncs),
        .SCK     (sck),
        .MISO    (miso)
    );

    spi_cnt_reader #(
        .CLK_DIV (3)
    ) dut3 (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .busy    (busy3),
        .done    (done3),
        .fs_cnt  (fs3),
        .fx_cnt  (fx3),
        .nCS     (ncs3),
        .SCK     (sck3),
        .MISO    (miso3)
    );

    // Responders: load the frame when nCS falls, advance one bit after each SCK fall.
    always @(posedge clk) begin
        if (ncs_q && !ncs) tx_sr <= frame;
        else if (sck_q && !sck && !ncs) tx_sr <= {tx_sr[62:0], 1'b0};
        ncs_q <= ncs;
        sck_q <= sck;
        if (ncs3_q && !ncs3) tx_sr3 <= frame3;
        else if (sck3_q && !sck3 && !ncs3) tx_sr3 <= {tx_sr3[62:0], 1'b0};
        ncs3_q <= ncs3;
        sck3_q <= sck3;
    end

    assign miso  = tx_sr[63];
    assign miso3 = tx_sr3[63];

    always @(posedge sck)  rises++;
    always @(posedge sck3) rises3++;
    always @(posedge clk) if (done) dones++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulses start for one cycle and waits for done. lat counts cycles after the start
    // cycle, so done at lat=517 is the 518th cycle counting the start cycle.
    task automatic run_frame(output int lat, output bit ok);
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("busy_in_start_cycle", busy, 1'b1);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 2000) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles", lat);
        end
    endtask

    typedef struct {
        logic [31:0] fs_in;
        logic [31:0] fx_in;
        logic [31:0] fs_exp;
        logic [31:0] fx_exp;
        int          lat_exp;
        int          rises_exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, r0, d0, n, cnt;
        int first_low, first_high, last_high, ncs_high, gap;
        bit ok;

        vecs[0] = '{32'h05F5E100, 32'h00989680, 32'h05F5E100, 32'h00989680, 517, 64};
        vecs[1] = '{32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555, 517, 64};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 517, 64};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 517, 64};
        vecs[4] = '{32'h00000001, 32'h80000000, 32'h00000001, 32'h80000000, 517, 64};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ncs", ncs, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fs", fs, 32'h0);
        chk("rst_fx", fx, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            frame = {vecs[i].fs_in, vecs[i].fx_in};
            r0 = rises;
            run_frame(lat, ok);
            chk("vec_latency", lat, vecs[i].lat_exp);
            chk("vec_fs", fs, vecs[i].fs_exp);
            chk("vec_fx", fx, vecs[i].fx_exp);
            chk("vec_sck_rises", rises - r0, vecs[i].rises_exp);
            $display("frame %0d: fs=%08h fx=%08h lat=%0d rises=%0d", i, fs, fx, lat, rises - r0);
            @(posedge clk);
            #1;
            chk("vec_done_one_cycle", done, 1'b0);
            chk("vec_busy_drops", busy, 1'b0);
            chk("vec_fs_stable", fs, vecs[i].fs_exp);
            repeat (4) @(posedge clk);
        end

        // CLK_DIV=3 instance: alternating pattern, plus nCS setup/hold around SCK activity.
        frame3 = 64'hAAAAAAAA_55555555;
        r0 = rises3;
        first_low = -1; first_high = -1; last_high = -1; ncs_high = -1;
        @(negedge clk);
        start3 = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 2000) begin
            @(posedge clk);
            #1;
            start3 = 1'b0;
            n++;
            if (!ncs3 && first_low < 0) first_low = n;
            if (sck3 && first_high < 0) first_high = n;
            if (sck3) last_high = n;
            if (done3) ok = 1'b1;
        end
        lat = n;
        @(posedge clk);
        #1;
        n++;
        if (ncs3) ncs_high = n;
        chk("div3_latency", lat, 389);
        chk("div3_fs", fs3, 32'hAAAAAAAA);
        chk("div3_fx", fx3, 32'h55555555);
        chk("div3_sck_rises", rises3 - r0, 64);
        chk("div3_setup_ge_2", (first_low > 0) && (first_high - first_low >= 2), 1'b1);
        chk("div3_hold_ge_2", (ncs_high > 0) && (ncs_high - (last_high + 1) >= 2), 1'b1);
        $display("frame div3: fs=%08h fx=%08h lat=%0d setup=%0d hold=%0d",
                 fs3, fx3, lat, first_high - first_low, ncs_high - (last_high + 1));
        repeat (4) @(posedge clk);

        // Extra starts at cycles 10, 200 and 517 (the done cycle) must all be ignored.
        frame = 64'h0BADF00D_12345678;
        r0 = rises;
        d0 = dones;
        cnt = 0;
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        #1;
        if (!busy) cnt++;
        for (int k = 1; k <= 700; k++) begin
            @(posedge clk);
            #1;
            start = (k == 10 || k == 200 || k == 517);
            if (k <= 517 && !busy) cnt++;
            if (done && lat < 0) lat = k;
        end
        start = 1'b0;
        chk("ign_busy_low_cycles", cnt, 0);
        chk("ign_done_cycle", lat, 517);
        chk("ign_done_count", dones - d0, 1);
        chk("ign_sck_rises", rises - r0, 64);
        chk("ign_fs", fs, 32'h0BADF00D);
        chk("ign_fx", fx, 32'h12345678);
        chk("ign_idle_ncs", ncs, 1'b1);
        $display("frame ignore: dones=%0d rises=%0d done_at=%0d", dones - d0, rises - r0, lat);

        // Reset during bit 30: lines return to idle at once, nothing is published.
        frame = 64'hCAFEBABE_DEADBEEF;
        r0 = rises;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (rises - r0 < 31 && n < 2000) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        chk("rst_mid_reached_bit30", rises - r0, 31);
        d0 = dones;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ncs", ncs, 1'b1);
        chk("rst_mid_sck", sck, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_fs", fs, 32'h0);
        chk("rst_mid_fx", fx, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (!ncs) cnt++;
        end
        chk("rst_mid_no_done", dones - d0, 0);
        chk("rst_mid_ncs_idle", cnt, 0);
        chk("rst_mid_fs_kept", fs, 32'h0);
        $display("frame reset: dones=%0d ncs_low_cycles=%0d", dones - d0, cnt);
        frame = 64'h13579BDF_2468ACE0;
        r0 = rises;
        run_frame(lat, ok);
        chk("after_rst_latency", lat, 517);
        chk("after_rst_fs", fs, 32'h13579BDF);
        chk("after_rst_fx", fx, 32'h2468ACE0);
        chk("after_rst_rises", rises - r0, 64);
        $display("frame after reset: fs=%08h fx=%08h lat=%0d", fs, fx, lat);
        repeat (4) @(posedge clk);

        // Back-to-back: start in the cycle right after done.
        frame = 64'h11111111_22222222;
        run_frame(lat, ok);
        chk("b2b_first_fs", fs, 32'h11111111);
        frame = 64'hFFFFFFFF_00000000;
        gap = 0;
        if (ncs) gap++;
        @(posedge clk);
        #1;
        if (ncs) gap++;
        start = 1'b1;
        r0 = rises;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 2000) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (n <= 3 && ncs) gap++;
            if (done) ok = 1'b1;
        end
        chk("b2b_ncs_high_gap", gap, 1);
        chk("b2b_latency", n, 517);
        chk("b2b_fs", fs, 32'hFFFFFFFF);
        chk("b2b_fx", fx, 32'h00000000);
        chk("b2b_rises", rises - r0, 64);
        $display("frame b2b: fs=%08h fx=%08h gap=%0d lat=%0d", fs, fx, gap, n);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
